// File: rtl/int_arb_pkg.sv
// Shared types and constants for the interrupt arbiter.
// The INT_ARB_RR_EN macro switches selection from fixed priority to round-robin.
package int_arb_pkg;

  localparam int NUM_SRC_MAX = 8;

  // Smallest width able to hold an id in 0..n-1 (at least 1 bit).
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int ID_W_MAX = id_width(NUM_SRC_MAX);

  // Folds an index in 0..2n-1 back into 0..n-1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    SERVICE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/int_prio_picker.sv
// Combinational picker over a request vector.
// Fixed lowest-index priority by default; round-robin from start_i when INT_ARB_RR_EN is defined.
module int_prio_picker
  import int_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic               any_valid_o,
  output logic [ID_W-1:0]    id_o
);

  assign any_valid_o = |req_i;

`ifdef INT_ARB_RR_EN
  // Scan from the farthest offset down so the nearest requester after start_i wins.
  always_comb begin
    // NOTE: default first so every path assigns id_o and no latch is inferred.
    id_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(int'(start_i) + k, NUM_SRC)]) begin
        id_o = ID_W'(wrap_idx(int'(start_i) + k, NUM_SRC));
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start_i;

  always_comb begin
    id_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_i[k]) id_o = ID_W'(k);
    end
  end
`endif

endmodule

// File: rtl/int_arbiter.sv
// Arbitrates NUM_SRC edge-triggered interrupt sources onto one ICU request/ack handshake.
// Define INT_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module int_arbiter
  import int_arb_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               icu_ack,
  input  logic               eoi,
  output logic               int_flag,
  output logic [31:0]        vector_pc,
  output logic [ID_W-1:0]    active_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  arb_state_e         state_q;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] edge_set, grant_clr;
  logic               int_flag_q, in_service_q, eoi_seen_q;
  logic [ID_W-1:0]    active_id_q;
  logic [31:0]        vector_pc_q;
  logic               any_valid;
  logic [ID_W-1:0]    pick_id, start_ptr;
  logic [31:0]        pick_pc;

  assign edge_set  = irq_in & ~irq_q;
  assign grant_clr = (state_q == REQ && icu_ack) ? (NUM_SRC'(1) << active_id_q) : '0;
  // A fresh edge on the bit being granted survives the clear.
  assign pending_d = (pending_q & ~grant_clr) | edge_set;
  assign pick_pc   = VEC_BASE + (32'(pick_id) * VEC_STRIDE);

`ifdef INT_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;
  assign rr_ptr_d  = (active_id_q == ID_W'(NUM_SRC - 1)) ? '0 : active_id_q + 1'b1;
  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif

  int_prio_picker #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_picker (
    .req_i      (pending_q & ~irq_mask),
    .start_i    (start_ptr),
    .any_valid_o(any_valid),
    .id_o       (pick_id)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      int_flag_q   <= 1'b0;
      in_service_q <= 1'b0;
      eoi_seen_q   <= 1'b0;
      active_id_q  <= '0;
      vector_pc_q  <= VEC_BASE;
`ifdef INT_ARB_RR_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      irq_q     <= irq_in;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          int_flag_q   <= 1'b0;
          in_service_q <= 1'b0;
          eoi_seen_q   <= 1'b0;
          if (enable && any_valid) begin
            state_q      <= REQ;
            active_id_q  <= pick_id;
            vector_pc_q  <= pick_pc;
            int_flag_q   <= 1'b1;
            in_service_q <= 1'b1;
          end
        end
        REQ: begin
          if (icu_ack) begin
            state_q    <= ACKED;
            int_flag_q <= 1'b0;
            eoi_seen_q <= 1'b0;
`ifdef INT_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
          end
        end
        ACKED: begin
          // An early EOI is remembered so the handshake can finish straight to IDLE.
          if (!icu_ack) begin
            eoi_seen_q <= 1'b0;
            if (eoi_seen_q || eoi) begin
              state_q      <= IDLE;
              in_service_q <= 1'b0;
            end else begin
              state_q <= SERVICE;
            end
          end else if (eoi) begin
            eoi_seen_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          int_flag_q   <= 1'b0;
          in_service_q <= 1'b0;
          eoi_seen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign int_flag   = int_flag_q;
  assign in_service = in_service_q;
  assign active_id  = active_id_q;
  assign vector_pc  = vector_pc_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed self-checking bench for int_arbiter (default parameters).
module tb_int_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  irq_in;
  logic [3:0]  irq_mask;
  logic        icu_ack;
  logic        eoi;
  logic        int_flag;
  logic [31:0] vector_pc;
  logic [1:0]  active_id;
  logic        in_service;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  int_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .icu_ack   (icu_ack),
    .eoi       (eoi),
    .int_flag  (int_flag),
    .vector_pc (vector_pc),
    .active_id (active_id),
    .in_service(in_service),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_int_flag"},   32'(int_flag),   32'h0);
    check({tag, "_in_service"}, 32'(in_service), 32'h0);
    check({tag, "_active_id"},  32'(active_id),  32'h0);
    check({tag, "_vector_pc"},  vector_pc,       32'h0);
    check({tag, "_pending"},    32'(pending),    32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    irq_in   = 4'b0000;
    irq_mask = 4'b0000;
    icu_ack  = 1'b0;
    eoi      = 1'b0;
    #2;
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;
    tick();

`ifdef INT_ARB_RR_EN
    // Sources 0 and 1 re-raised every round; grants alternate.
    irq_in = 4'b0011;
    tick();
    check("rr_pending", 32'(pending), 32'h3);
    for (int r = 0; r < 4; r++) begin
      tick();
      check($sformatf("rr_grant%0d_flag", r), 32'(int_flag), 32'h1);
      check($sformatf("rr_grant%0d_id", r), 32'(active_id), 32'(r % 2));
      icu_ack = 1'b1; irq_in = 4'b0000;
      tick();
      icu_ack = 1'b0; irq_in = 4'b0011;
      tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
    end
`else
    // Single request on source 2.
    irq_in = 4'b0100;
    tick();
    check("single_pending", 32'(pending), 32'h4);
    check("single_flag_e0", 32'(int_flag), 32'h0);
    tick();
    check("single_flag_e1", 32'(int_flag), 32'h1);
    check("single_id", 32'(active_id), 32'h2);
    check("single_pc", vector_pc, 32'h20);
    check("single_insvc", 32'(in_service), 32'h1);
    icu_ack = 1'b1;
    tick();
    check("single_ack_pending", 32'(pending), 32'h0);
    check("single_ack_flag", 32'(int_flag), 32'h0);
    icu_ack = 1'b0;
    tick();
    check("single_service", 32'(in_service), 32'h1);
    eoi = 1'b1; irq_in = 4'b0000;
    tick();
    eoi = 1'b0;
    check("single_eoi", 32'(in_service), 32'h0);

    // Simultaneous rises on sources 3 and 1.
    irq_in = 4'b1010;
    tick();
    check("simul_pending", 32'(pending), 32'hA);
    tick();
    check("simul_first_id", 32'(active_id), 32'h1);
    check("simul_first_pc", vector_pc, 32'h10);
    icu_ack = 1'b1;
    tick();
    check("simul_first_clear", 32'(pending), 32'h8);
    icu_ack = 1'b0;
    tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("simul_idle", 32'(int_flag), 32'h0);
    tick();
    check("simul_second_flag", 32'(int_flag), 32'h1);
    check("simul_second_id", 32'(active_id), 32'h3);
    check("simul_second_pc", vector_pc, 32'h30);
    icu_ack = 1'b1;
    tick();
    icu_ack = 1'b0;
    tick();
    eoi = 1'b1; irq_in = 4'b0000;
    tick();
    eoi = 1'b0;

    // Masked source keeps its pending bit but is not granted.
    irq_mask = 4'b0001; irq_in = 4'b0001;
    tick();
    check("mask_pending", 32'(pending), 32'h1);
    tick();
    tick();
    check("mask_no_grant", 32'(int_flag), 32'h0);
    irq_mask = 4'b0000;
    tick();
    check("unmask_flag", 32'(int_flag), 32'h1);
    check("unmask_id", 32'(active_id), 32'h0);
    icu_ack = 1'b1;
    tick();
    icu_ack = 1'b0;
    tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0; enable = 1'b0;

    // Enable gating.
    irq_in = 4'b0101;
    tick();
    check("en_pending", 32'(pending), 32'h4);
    tick();
    tick();
    check("en_off_no_grant", 32'(int_flag), 32'h0);
    enable = 1'b1;
    tick();
    check("en_on_flag", 32'(int_flag), 32'h1);
    check("en_on_id", 32'(active_id), 32'h2);
    enable = 1'b0;
    tick();
    check("en_drop_holds_req", 32'(int_flag), 32'h1);

    // Re-trigger of source 2 in the same cycle its pending bit is cleared.
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0101; icu_ack = 1'b1;
    tick();
    check("retrig_pending", 32'(pending), 32'h4);
    check("retrig_flag", 32'(int_flag), 32'h0);

    // EOI arriving while ack is still high finishes straight to IDLE.
    eoi = 1'b1;
    tick();
    check("acked_eoi_insvc", 32'(in_service), 32'h1);
    eoi = 1'b0; icu_ack = 1'b0;
    tick();
    check("acked_eoi_idle", 32'(in_service), 32'h0);
    check("acked_eoi_pending", 32'(pending), 32'h4);

    // No preemption: source 0 rises while source 2 is requested.
    irq_in = 4'b0100; enable = 1'b1;
    tick();
    check("preempt_grant_id", 32'(active_id), 32'h2);
    irq_in = 4'b0101;
    tick();
    check("preempt_pending", 32'(pending), 32'h5);
    check("preempt_id_held", 32'(active_id), 32'h2);
    check("preempt_pc_held", vector_pc, 32'h20);
    icu_ack = 1'b1;
    tick();
    check("preempt_ack_pending", 32'(pending), 32'h1);
    icu_ack = 1'b0;
    tick();
    check("preempt_service_flag", 32'(int_flag), 32'h0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    check("preempt_next_flag", 32'(int_flag), 32'h1);
    check("preempt_next_id", 32'(active_id), 32'h0);
    check("preempt_next_pc", vector_pc, 32'h0);

    // Asynchronous reset while in SERVICE.
    icu_ack = 1'b1;
    tick();
    icu_ack = 1'b0; irq_in = 4'b0111;
    tick();
    check("svc_insvc", 32'(in_service), 32'h1);
    check("svc_pending", 32'(pending), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    irq_in = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Shares the single interrupt-injection controller (ICU) among NUM_SRC external interrupt sources.
- Edge-captures requests into pending bits and picks one unmasked pending source.
- Drives the ICU's int_flag and absorbs its level ack handshake.
- Supplies the handler PC and blocks further requests until the handler signals end-of-interrupt (EOI, on RTI retire).

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of source id; must equal clog2(NUM_SRC).
- VEC_BASE, 32'h0000_0000, handler address of source 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between consecutive handlers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global interrupt enable; gates only the IDLE->REQ transition.
- irq_in  in  NUM_SRC  raw source request lines, rising-edge sensitive.
- irq_mask  in  NUM_SRC  1 = source excluded from selection; its pending bit is kept.
- icu_ack  in  1  ICU acknowledge, held high until int_flag drops.
- eoi  in  1  one-cycle pulse when the handler's RTI retires.
- int_flag  out  1  interrupt request to the ICU.
- vector_pc  out  32  handler address of active_id.
- active_id  out  ID_W  id of the granted source.
- in_service  out  1  high from grant until EOI.
- pending  out  NUM_SRC  captured, not-yet-granted requests.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - int_flag=0, in_service=0, active_id=0, vector_pc=VEC_BASE.
  - pending=0, irq_q=0, RR pointer=0.
- Edge capture:
  - irq_q <= irq_in every cycle.
  - pending[i] sets when irq_in[i]=1 and irq_q[i]=0.
  - pending[i] clears on the grant-clear event below.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- State IDLE:
  - int_flag=0, in_service=0.
  - If enable=1 and (pending & ~irq_mask)!=0: latch the picked id into active_id, latch vector_pc=VEC_BASE+active_id*VEC_STRIDE (32-bit wrap), go to REQ.
  - eoi in IDLE is ignored.
- State REQ:
  - int_flag=1, in_service=1.
  - active_id and vector_pc are frozen; a higher-priority arrival does not preempt.
  - enable dropping does not withdraw the request.
  - On icu_ack=1: clear pending[active_id], go to ACKED.
- State ACKED:
  - int_flag=0, in_service=1.
  - Wait for icu_ack=0, then go to SERVICE.
  - If eoi arrives here, record it and go directly to IDLE once icu_ack=0.
- State SERVICE:
  - int_flag=0, in_service=1.
  - On eoi=1: go to IDLE. A new grant can follow in the next cycle.
- Latency:
  - irq_in rise sampled at edge E0 -> pending set after E0.
  - int_flag=1 after E1 (if enable=1, unmasked, state IDLE).
- Selection: fixed priority, lowest index wins.
- All outputs are registered.
- Unused state encodings recover to IDLE.

Optional Feature:
- Macro INT_ARB_RR_EN.
- Defined: round-robin selection. The search starts at (last granted id + 1) mod NUM_SRC. The RR pointer updates on the REQ->ACKED transition and resets to 0.
- Undefined: fixed priority, lowest index wins; no RR pointer register.

Decomposition:
- Package int_arb_pkg:
  - State encoding: IDLE=2'd0, REQ=2'd1, ACKED=2'd2, SERVICE=2'd3.
  - NUM_SRC_MAX=8 and ID width helper constants.
- Sub-module int_prio_picker:
  - Purely combinational.
  - Inputs: request vector and start pointer. Outputs: any_valid and picked id.
  - Contains the fixed/round-robin variants under INT_ARB_RR_EN.

Test Plan:
- Single request: irq_in[2] rises, enable=1 -> pending=4'b0100; int_flag=1 two edges after the rise; active_id=2; vector_pc=32'h20. Drive icu_ack=1 -> pending=0, int_flag=0. Drop icu_ack, then pulse eoi -> in_service=0.
- Simultaneous rises on irq_in[3] and irq_in[1] -> first grant id 1 (vector 32'h10). After eoi, second grant id 3 (vector 32'h30).
- Mask and enable gating:
  - irq_mask[0]=1 with irq_in[0] rising -> pending[0]=1, int_flag stays 0.
  - Clear the mask -> grant id 0.
  - With enable=0, no grant occurs until enable=1.
- No preemption: irq_in[0] rises while REQ holds id 3 -> active_id stays 3 until ack. Id 0 is granted only after eoi.
- Re-trigger during clear: irq_in[2] re-rises in the same cycle icu_ack clears pending[2] -> pending[2] remains 1.
- Reset mid-service: assert reset in SERVICE -> all outputs return to reset values immediately, without waiting for a clock edge.
- INT_ARB_RR_EN defined: sources 0 and 1 held pending continuously -> grants alternate 0,1,0,1.
